// File: rtl/bsr_pkg.sv
// Package: bsr_pkg
// Shared definitions for the bit_shift_rotate ALU slice.
//   POS_W   : width of the clear-bit position index
//   dir_e   : shift/rotate direction encoding
//   flags_t : zero/carry/overflow status-flag bundle
package bsr_pkg;

    localparam int POS_W = 4;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
    } flags_t;

endpackage

// File: rtl/bit_shift_rotate_flag_control.sv
// Module: flag_control
// Holds the registered zero/carry/overflow status flags.
//   clk      in   system clock, rising edge
//   reset    in   synchronous, active-high; clears all flags
//   flag_we  in   load enable (only when BSR_FLAG_WE_EN is defined)
//   flags_d  in   next flag values
//   flags_q  out  registered flag values
// Configuration macro: BSR_FLAG_WE_EN
module flag_control
    import bsr_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
`ifdef BSR_FLAG_WE_EN
    input  logic   flag_we,
`endif
    input  flags_t flags_d,
    output flags_t flags_q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= '0;
`ifdef BSR_FLAG_WE_EN
        end else if (flag_we) begin
            flags_q <= flags_d;
`else
        end else begin
            flags_q <= flags_d;
`endif
        end
    end

endmodule

// File: rtl/bit_shift_rotate.sv
// Module: bit_shift_rotate
// Bit-manipulation slice between the ALU result bus and the status register.
//   reg_in / reg_out / shift_carry : one-position shift or rotate (combinational)
//   shift_enable, shift_dir        : logical shift, 0=left 1=right (highest priority)
//   rotate_enable, rotate_dir      : rotate, 0=left 1=right
//   pos / reg_out_clear            : reg_in with bit pos cleared (combinational)
//   *_flag_in / *_flag             : registered status flags, one-cycle latency
//   clk, reset                     : clock and synchronous active-high reset (flags only)
//   flag_we                        : flag load enable (only when BSR_FLAG_WE_EN is defined)
// Configuration macro: BSR_FLAG_WE_EN
module bit_shift_rotate
    import bsr_pkg::*;
#(
    parameter int WORD_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] reg_in,
    input  logic [POS_W-1:0]     pos,
    input  logic                 shift_enable,
    input  logic                 shift_dir,
    input  logic                 rotate_enable,
    input  logic                 rotate_dir,
    output logic [WORD_SIZE-1:0] reg_out,
    output logic                 shift_carry,
    output logic [WORD_SIZE-1:0] reg_out_clear,
    input  logic                 zero_flag_in,
    input  logic                 carry_flag_in,
    input  logic                 overflow_flag_in,
`ifdef BSR_FLAG_WE_EN
    input  logic                 flag_we,
`endif
    output logic                 zero_flag,
    output logic                 carry_flag,
    output logic                 overflow_flag
);

    localparam int W = WORD_SIZE;

    // Shift/rotate: shift has priority; the carry is the bit leaving the word.
    always_comb begin
        reg_out     = reg_in;
        shift_carry = 1'b0;
        if (shift_enable) begin
            if (dir_e'(shift_dir) == DIR_LEFT) begin
                reg_out     = {reg_in[W-2:0], 1'b0};
                shift_carry = reg_in[W-1];
            end else begin
                reg_out     = {1'b0, reg_in[W-1:1]};
                shift_carry = reg_in[0];
            end
        end else if (rotate_enable) begin
            if (dir_e'(rotate_dir) == DIR_LEFT) begin
                reg_out     = {reg_in[W-2:0], reg_in[W-1]};
                shift_carry = reg_in[W-1];
            end else begin
                reg_out     = {reg_in[0], reg_in[W-1:1]};
                shift_carry = reg_in[0];
            end
        end
    end

    // Clear mask built by comparison so an out-of-range pos selects no bit
    // (no wrap, no X) rather than relying on shift semantics.
    always_comb begin
        reg_out_clear = reg_in;
        for (int i = 0; i < W; i++) begin
            if (32'(pos) == i) reg_out_clear[i] = 1'b0;
        end
    end

    flags_t flags_d;
    flags_t flags_q;

    assign flags_d = '{zero: zero_flag_in, carry: carry_flag_in, overflow: overflow_flag_in};

    flag_control u_flag_control (
        .clk     (clk),
        .reset   (reset),
`ifdef BSR_FLAG_WE_EN
        .flag_we (flag_we),
`endif
        .flags_d (flags_d),
        .flags_q (flags_q)
    );

    assign zero_flag     = flags_q.zero;
    assign carry_flag    = flags_q.carry;
    assign overflow_flag = flags_q.overflow;

endmodule

// File: tb/tb_bit_shift_rotate.sv
// Directed testbench for bit_shift_rotate (WORD_SIZE = 8).
module tb_bit_shift_rotate;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] reg_in;
    logic [3:0] pos;
    logic       shift_enable, shift_dir, rotate_enable, rotate_dir;
    logic [7:0] reg_out, reg_out_clear;
    logic       shift_carry;
    logic       zero_flag_in, carry_flag_in, overflow_flag_in;
    logic       zero_flag, carry_flag, overflow_flag;
`ifdef BSR_FLAG_WE_EN
    logic       flag_we = 1'b1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bit_shift_rotate #(.WORD_SIZE(8)) dut (
        .clk              (clk),
        .reset            (reset),
        .reg_in           (reg_in),
        .pos              (pos),
        .shift_enable     (shift_enable),
        .shift_dir        (shift_dir),
        .rotate_enable    (rotate_enable),
        .rotate_dir       (rotate_dir),
        .reg_out          (reg_out),
        .shift_carry      (shift_carry),
        .reg_out_clear    (reg_out_clear),
        .zero_flag_in     (zero_flag_in),
        .carry_flag_in    (carry_flag_in),
        .overflow_flag_in (overflow_flag_in),
`ifdef BSR_FLAG_WE_EN
        .flag_we          (flag_we),
`endif
        .zero_flag        (zero_flag),
        .carry_flag       (carry_flag),
        .overflow_flag    (overflow_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sr(input logic [7:0] v, input logic se, input logic sd,
                      input logic re, input logic rd,
                      input logic [7:0] exp_out, input logic exp_c, input string tag);
        reg_in = v; shift_enable = se; shift_dir = sd; rotate_enable = re; rotate_dir = rd;
        #1;
        chk({tag, ".out"}, 32'(reg_out), 32'(exp_out));
        chk({tag, ".c"}, 32'(shift_carry), 32'(exp_c));
    endtask

    task automatic clr(input logic [7:0] v, input logic [3:0] p, input logic [7:0] exp, input string tag);
        reg_in = v; pos = p;
        #1;
        chk(tag, 32'(reg_out_clear), 32'(exp));
    endtask

    // Apply flag inputs, clock one edge, sample #1 after it.
    task automatic fl(input logic r, input logic [2:0] in, input logic [2:0] exp, input string tag);
        reset = r;
        {zero_flag_in, carry_flag_in, overflow_flag_in} = in;
        @(posedge clk);
        #1;
        chk(tag, 32'({zero_flag, carry_flag, overflow_flag}), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; reg_in = '0; pos = '0;
        shift_enable = 0; shift_dir = 0; rotate_enable = 0; rotate_dir = 0;
        zero_flag_in = 0; carry_flag_in = 0; overflow_flag_in = 0;
        #2;

        // Shift/rotate
        sr(8'b11001100, 1, 0, 0, 0, 8'b10011000, 1, "shl");
        sr(8'b11001100, 1, 1, 0, 0, 8'b01100110, 0, "shr");
        sr(8'b11001100, 0, 0, 1, 0, 8'b10011001, 1, "rol");
        sr(8'b11001100, 0, 0, 1, 1, 8'b01100110, 0, "ror");
        sr(8'b10000001, 1, 1, 0, 0, 8'b01000000, 1, "shr81");
        sr(8'b10000001, 0, 0, 1, 1, 8'b11000000, 1, "ror81");
        sr(8'b10000001, 0, 0, 1, 0, 8'b00000011, 1, "rol81");
        sr(8'b10000001, 1, 0, 1, 1, 8'b00000010, 1, "both_shl");
        sr(8'b01000001, 1, 1, 1, 0, 8'b00100000, 1, "both_shr");
        sr(8'b10110001, 0, 1, 0, 1, 8'b10110001, 0, "pass");

        // Clear
        clr(8'b10101010, 4'd3, 8'b10100010, "clr3");
        clr(8'b01111111, 4'd7, 8'b01111111, "clr7");
        clr(8'b11111111, 4'd7, 8'b01111111, "clr7b");
        clr(8'b11111111, 4'd0, 8'b11111110, "clr0");
        clr(8'b11111111, 4'd8, 8'b11111111, "clr8");
        clr(8'b10101010, 4'd9, 8'b10101010, "clr9");
        clr(8'b11111111, 4'd15, 8'b11111111, "clr15");

        // Flags
        @(negedge clk);
        fl(1, 3'b111, 3'b000, "rst");
        fl(0, 3'b110, 3'b110, "fl110");
        fl(0, 3'b001, 3'b001, "fl001");
        fl(0, 3'b111, 3'b111, "fl111");
        fl(1, 3'b111, 3'b000, "rst_mid");
        fl(0, 3'b101, 3'b101, "fl101");
`ifdef BSR_FLAG_WE_EN
        flag_we = 1'b0;
        fl(0, 3'b010, 3'b101, "we0_hold");
        fl(1, 3'b010, 3'b000, "we0_rst");
        flag_we = 1'b1;
        fl(0, 3'b010, 3'b010, "we1_load");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
